// File: rtl/eeg_pea_eng_pe_mc_if.sv
// Stream bundle for the multi-channel conv PE: sparse activation/weight
// beats coming in and requantised output positions going out.
interface eeg_pea_eng_pe_mc_if #(
  parameter int NUM_OCH     = 4,
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int DATA_OUT_DW = 8,
  parameter int ARAM_ADD_AW = 10,
  parameter int CONV_WEI_DW = 3
);
  logic                           DIN_VLD;
  logic                           DIN_RDY;
  logic                           ACT_LST;
  logic                           WEI_LST;
  logic [DATA_ACT_DW-1:0]         ACT_DAT;
  logic [ARAM_ADD_AW-1:0]         ACT_ADD;
  logic [NUM_OCH*DATA_WEI_DW-1:0] WEI_DAT;
  logic [CONV_WEI_DW-1:0]         WEI_IDX;
  logic                           OUT_VLD;
  logic                           OUT_RDY;
  logic                           OUT_LST;
  logic [ARAM_ADD_AW-1:0]         OUT_ADD;
  logic [NUM_OCH*DATA_OUT_DW-1:0] OUT_DAT;

  // PE side: consumes beats, produces outputs
  modport slave (
    input  DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX, OUT_RDY,
    output DIN_RDY, OUT_VLD, OUT_LST, OUT_ADD, OUT_DAT
  );

  // Fetch/writer side: produces beats, consumes outputs
  modport master (
    output DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX, OUT_RDY,
    input  DIN_RDY, OUT_VLD, OUT_LST, OUT_ADD, OUT_DAT
  );
endinterface

// File: rtl/eeg_pea_eng_pe_mc.sv
// Multi-output-channel conv PE. Accumulates NUM_OCH parallel sliding psum
// windows from a sparse activation stream and retires completed output
// positions through per-channel requantisation.
module eeg_pea_eng_pe_mc #(
  parameter int NUM_OCH     = 4,
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int DATA_OUT_DW = 8,
  parameter int DATA_SUM_DW = 24,
  parameter int DATA_SUM_NW = 8,
  parameter int ARAM_ADD_AW = 10,
  parameter int CONV_WEI_DW = 3,
  parameter int CONV_RUN_DW = 3,
  parameter int CONV_MUL_DW = 16,
  parameter int CONV_ADD_DW = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           IS_IDLE,
  input  logic [CONV_RUN_DW-1:0]         CFG_CONV_RUN,
  input  logic [CONV_WEI_DW-1:0]         CFG_CONV_PAD,
  input  logic [NUM_OCH*CONV_MUL_DW-1:0] CFG_CONV_MUL,
  input  logic [NUM_OCH*CONV_ADD_DW-1:0] CFG_CONV_ADD,
  input  logic [4:0]                     CFG_CONV_SFT,
  input  logic [ARAM_ADD_AW-1:0]         CFG_CONV_LST,
  input  logic                           CFG_RELU,
  eeg_pea_eng_pe_mc_if.slave             bus
);

  // Requant datapath is wide enough for psum * {0,mul} + offset with no loss.
  localparam int REQ_DW = DATA_SUM_DW + CONV_MUL_DW + 2;
  // Range comparison width: address plus PAD*RUN without wrap.
  localparam int CMP_DW = ARAM_ADD_AW + CONV_WEI_DW + CONV_RUN_DW + 1;
  localparam int PRD_DW = DATA_ACT_DW + DATA_WEI_DW;

  localparam logic signed [REQ_DW-1:0] OUT_MAX_C =
    {{(REQ_DW-DATA_OUT_DW+1){1'b0}}, {(DATA_OUT_DW-1){1'b1}}};
  localparam logic signed [REQ_DW-1:0] OUT_MIN_C =
    {{(REQ_DW-DATA_OUT_DW+1){1'b1}}, {(DATA_OUT_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLOW  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          state_s;
  logic signed [DATA_SUM_DW-1:0]   psum_r [DATA_SUM_NW][NUM_OCH];
  logic [ARAM_ADD_AW-1:0]          base_r;
  logic                            out_vld_r;
  logic                            out_lst_r;
  logic [ARAM_ADD_AW-1:0]          out_add_r;
  logic [NUM_OCH*DATA_OUT_DW-1:0]  out_dat_r;

  logic                            din_rdy_s;
  logic                            accept_s;
  logic                            retire_s;
  logic                            retire_lst_s;
  logic                            clear_s;
  logic                            out_free_s;
  logic                            lst_hold_s;
  logic                            beat_lst_s;
  logic                            out_range_s;
  logic [CMP_DW-1:0]               span_s;
  logic [CMP_DW-1:0]               lim_s;
  logic signed [DATA_SUM_DW-1:0]   prod_s [NUM_OCH];
  logic [NUM_OCH*DATA_OUT_DW-1:0]  req_s;

  // Multiply, add offset, shift with round-half-up, saturate, optional ReLU.
  function automatic logic [DATA_OUT_DW-1:0] requant(
    input logic [DATA_SUM_DW-1:0] psum,
    input logic [CONV_MUL_DW-1:0] mul,
    input logic [CONV_ADD_DW-1:0] ofs,
    input logic [4:0]             sft,
    input logic                   relu
  );
    logic signed [REQ_DW-1:0] p_ext;
    logic signed [REQ_DW-1:0] m_ext;
    logic signed [REQ_DW-1:0] a_ext;
    logic signed [REQ_DW-1:0] full;
    logic signed [REQ_DW-1:0] shf;
    logic signed [REQ_DW-1:0] rnd;
    logic signed [REQ_DW-1:0] y_full;
    logic [DATA_OUT_DW-1:0]   y;
    p_ext = {{(REQ_DW-DATA_SUM_DW){psum[DATA_SUM_DW-1]}}, psum};
    m_ext = {{(REQ_DW-CONV_MUL_DW){1'b0}}, mul};
    a_ext = {{(REQ_DW-CONV_ADD_DW){ofs[CONV_ADD_DW-1]}}, ofs};
    full  = p_ext * m_ext + a_ext;
    shf   = full >>> sft;
    rnd   = {REQ_DW{1'b0}};
    if (sft != 5'd0) begin
      rnd[0] = full[sft - 5'd1];
    end else begin
      rnd[0] = 1'b0;
    end
    y_full = shf + rnd;
    if (y_full > OUT_MAX_C) begin
      y = OUT_MAX_C[DATA_OUT_DW-1:0];
    end else if (y_full < OUT_MIN_C) begin
      y = OUT_MIN_C[DATA_OUT_DW-1:0];
    end else begin
      y = y_full[DATA_OUT_DW-1:0];
    end
    if (relu && y[DATA_OUT_DW-1]) begin
      y = {DATA_OUT_DW{1'b0}};
    end else begin
      y = y;
    end
    return y;
  endfunction

  assign IS_IDLE     = (state_r == ST_IDLE);
  assign bus.DIN_RDY = din_rdy_s;
  assign bus.OUT_VLD = out_vld_r;
  assign bus.OUT_LST = out_lst_r;
  assign bus.OUT_ADD = out_add_r;
  assign bus.OUT_DAT = out_dat_r;

  assign beat_lst_s   = bus.ACT_LST & bus.WEI_LST;
  assign out_free_s   = !out_vld_r || bus.OUT_RDY;
  // Once the row's last output sits in the register, nothing more may retire.
  assign lst_hold_s   = out_vld_r && out_lst_r;
  assign span_s       = CMP_DW'(CFG_CONV_PAD) * CMP_DW'(CFG_CONV_RUN);
  assign lim_s        = CMP_DW'(base_r) + span_s;
  assign out_range_s  = CMP_DW'(bus.ACT_ADD) > lim_s;
  assign accept_s     = bus.DIN_VLD && din_rdy_s;
  assign retire_lst_s = (state_r == ST_FLUSH) && (base_r >= CFG_CONV_LST);

  // Sign-extended per-channel products of the incoming beat.
  always_comb begin
    for (int c = 0; c < NUM_OCH; c++) begin
      logic signed [PRD_DW-1:0] p;
      p = $signed(bus.ACT_DAT) * $signed(bus.WEI_DAT[c*DATA_WEI_DW +: DATA_WEI_DW]);
      prod_s[c] = {{(DATA_SUM_DW-PRD_DW){p[PRD_DW-1]}}, p};
    end
  end

  // Requantised view of the window head for every channel.
  always_comb begin
    req_s = {(NUM_OCH*DATA_OUT_DW){1'b0}};
    for (int c = 0; c < NUM_OCH; c++) begin
      req_s[c*DATA_OUT_DW +: DATA_OUT_DW] = requant(
        psum_r[0][c],
        CFG_CONV_MUL[c*CONV_MUL_DW +: CONV_MUL_DW],
        CFG_CONV_ADD[c*CONV_ADD_DW +: CONV_ADD_DW],
        CFG_CONV_SFT,
        CFG_RELU);
    end
  end

  // Next-state, input ready and retire decision.
  always_comb begin
    state_s   = state_r;
    din_rdy_s = 1'b0;
    retire_s  = 1'b0;
    clear_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        din_rdy_s = 1'b1;
        if (bus.DIN_VLD) begin
          if (beat_lst_s) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_FLOW;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FLOW: begin
        // An out-of-range beat stalls while the head retires toward it.
        din_rdy_s = !(bus.DIN_VLD && out_range_s);
        retire_s  = bus.DIN_VLD && out_range_s && out_free_s;
        if (bus.DIN_VLD && !out_range_s && beat_lst_s) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_FLOW;
        end
      end
      ST_FLUSH: begin
        retire_s = out_free_s && !lst_hold_s;
        if (lst_hold_s && bus.OUT_RDY) begin
          state_s = ST_IDLE;
          clear_s = 1'b1;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Psum window: clear at row end, shift on retire, accumulate on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_SUM_NW; i++) begin
        for (int c = 0; c < NUM_OCH; c++) begin
          psum_r[i][c] <= {DATA_SUM_DW{1'b0}};
        end
      end
    end else if (clear_s) begin
      // Slots past the last output may hold leftovers; drop them.
      for (int i = 0; i < DATA_SUM_NW; i++) begin
        for (int c = 0; c < NUM_OCH; c++) begin
          psum_r[i][c] <= {DATA_SUM_DW{1'b0}};
        end
      end
    end else if (retire_s) begin
      for (int i = 0; i < DATA_SUM_NW-1; i++) begin
        for (int c = 0; c < NUM_OCH; c++) begin
          psum_r[i][c] <= psum_r[i+1][c];
        end
      end
      for (int c = 0; c < NUM_OCH; c++) begin
        psum_r[DATA_SUM_NW-1][c] <= {DATA_SUM_DW{1'b0}};
      end
    end else if (accept_s) begin
      for (int i = 0; i < DATA_SUM_NW; i++) begin
        if (bus.WEI_IDX == CONV_WEI_DW'(i)) begin
          for (int c = 0; c < NUM_OCH; c++) begin
            psum_r[i][c] <= psum_r[i][c] + prod_s[c];
          end
        end
      end
    end
  end

  // Window head address: seeded by the first beat, advanced per retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r <= {ARAM_ADD_AW{1'b0}};
    end else if (state_r == ST_IDLE && accept_s) begin
      base_r <= bus.ACT_ADD;
    end else if (retire_s) begin
      base_r <= base_r + ARAM_ADD_AW'(CFG_CONV_RUN);
    end else begin
      base_r <= base_r;
    end
  end

  // Output register: load on retire, drain on handshake, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_r <= 1'b0;
      out_lst_r <= 1'b0;
      out_add_r <= {ARAM_ADD_AW{1'b0}};
      out_dat_r <= {(NUM_OCH*DATA_OUT_DW){1'b0}};
    end else if (retire_s) begin
      out_vld_r <= 1'b1;
      out_lst_r <= retire_lst_s;
      out_add_r <= base_r;
      out_dat_r <= req_s;
    end else if (bus.OUT_RDY) begin
      out_vld_r <= 1'b0;
      out_lst_r <= 1'b0;
    end else begin
      out_vld_r <= out_vld_r;
      out_lst_r <= out_lst_r;
    end
  end

endmodule

// File: tb/tb_eeg_pea_eng_pe_mc.sv
// Bench for eeg_pea_eng_pe_mc (two output channels): directed rows for the
// documented corner cases, then randomized rows against a positional model.
module tb_eeg_pea_eng_pe_mc;
  localparam int NOCH = 2;

  logic        clk;
  logic        rst_n;
  logic        is_idle;
  logic [2:0]  cfg_run;
  logic [2:0]  cfg_pad;
  logic [31:0] cfg_mul;
  logic [47:0] cfg_add;
  logic [4:0]  cfg_sft;
  logic [9:0]  cfg_lst;
  logic        cfg_relu;
  int          mul_v [2];
  int          add_v [2];
  bit          rdy_rand;
  logic        rdy_force;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int add; int idx; int act; int w0; int w1; bit al; bit wl;
  } beat_t;

  beat_t       bq[$];
  int          stalls[$];
  logic [9:0]  cap_add[$];
  logic [15:0] cap_dat[$];
  logic        cap_lst[$];
  longint      exp_add[$];
  longint      exp_d0[$];
  longint      exp_d1[$];
  bit          exp_lst[$];

  eeg_pea_eng_pe_mc_if #(.NUM_OCH(NOCH), .DATA_ACT_DW(8), .DATA_WEI_DW(8),
    .DATA_OUT_DW(8), .ARAM_ADD_AW(10), .CONV_WEI_DW(3)) bus ();

  eeg_pea_eng_pe_mc #(.NUM_OCH(NOCH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IS_IDLE      (is_idle),
    .CFG_CONV_RUN (cfg_run),
    .CFG_CONV_PAD (cfg_pad),
    .CFG_CONV_MUL (cfg_mul),
    .CFG_CONV_ADD (cfg_add),
    .CFG_CONV_SFT (cfg_sft),
    .CFG_CONV_LST (cfg_lst),
    .CFG_RELU     (cfg_relu),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-ready driver, changes well after the rising edge.
  initial begin
    bus.OUT_RDY = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.OUT_RDY = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Record every output handshake.
  always @(negedge clk) begin
    if (rst_n && bus.OUT_VLD && bus.OUT_RDY) begin
      cap_add.push_back(bus.OUT_ADD);
      cap_dat.push_back(bus.OUT_DAT);
      cap_lst.push_back(bus.OUT_LST);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(int add, int idx, int act, int w0, int w1, bit lst);
    beat_t b;
    b.add = add; b.idx = idx; b.act = act; b.w0 = w0; b.w1 = w1;
    b.al = lst; b.wl = lst;
    return b;
  endfunction

  task automatic set_cfg(int run, int pad, int m0, int m1, int a0, int a1,
                         int sft, int lst, bit relu);
    cfg_run = 3'(run); cfg_pad = 3'(pad);
    mul_v[0] = m0; mul_v[1] = m1; add_v[0] = a0; add_v[1] = a1;
    cfg_mul = {16'(m1), 16'(m0)};
    cfg_add = {24'(a1), 24'(a0)};
    cfg_sft = 5'(sft); cfg_lst = 10'(lst); cfg_relu = relu;
  endtask

  function automatic longint wrap24(longint v);
    longint w;
    w = v & 64'hFF_FFFF;
    if (w >= 64'sd8388608) w = w - 64'sd16777216;
    return w;
  endfunction

  // Round-half-up requant as floor((m + 2^(s-1)) / 2^s), then clamp.
  function automatic longint ref_rq(longint p, longint mul, longint ofs, int sft, bit relu);
    longint m, d, t, y;
    m = p * mul + ofs;
    if (sft == 0) begin
      y = m;
    end else begin
      d = 64'sd1 <<< sft;
      t = m + d / 2;
      y = t / d;
      if ((t % d) != 0 && t < 0) y = y - 1;
    end
    if (y > 127) y = 127;
    else if (y < -128) y = -128;
    if (relu && y < 0) y = 0;
    return y;
  endfunction

  // Expected outputs: output j sits at base0 + j*RUN; a beat targets the
  // position IDX steps past the head it sees, the head having advanced just
  // far enough that the beat lies within PAD*RUN of it.
  task automatic build_model();
    longint b0, pr, need, kk, addr, p0, p1;
    longint ps0[int];
    longint ps1[int];
    int k, j, run;
    exp_add.delete(); exp_d0.delete(); exp_d1.delete(); exp_lst.delete();
    run = int'(cfg_run);
    b0 = bq[0].add;
    pr = int'(cfg_pad) * run;
    k = 0;
    foreach (bq[i]) begin
      need = bq[i].add - b0 - pr;
      if (need > 0) begin
        kk = (need + run - 1) / run;
        if (kk > k) k = int'(kk);
      end
      j = k + bq[i].idx;
      if (!ps0.exists(j)) begin ps0[j] = 0; ps1[j] = 0; end
      ps0[j] = wrap24(ps0[j] + bq[i].act * bq[i].w0);
      ps1[j] = wrap24(ps1[j] + bq[i].act * bq[i].w1);
    end
    for (int n = 0; n < 4000; n++) begin
      addr = b0 + n * run;
      p0 = ps0.exists(n) ? ps0[n] : 0;
      p1 = ps1.exists(n) ? ps1[n] : 0;
      exp_add.push_back(addr);
      exp_d0.push_back(ref_rq(p0, mul_v[0], add_v[0], int'(cfg_sft), cfg_relu));
      exp_d1.push_back(ref_rq(p1, mul_v[1], add_v[1], int'(cfg_sft), cfg_relu));
      exp_lst.push_back((n >= k) && (addr >= int'(cfg_lst)));
      if (exp_lst[n]) break;
    end
  endtask

  task automatic send_beat(input beat_t b, output int stall);
    bus.ACT_ADD = 10'(b.add);
    bus.ACT_DAT = 8'(b.act);
    bus.WEI_DAT = {8'(b.w1), 8'(b.w0)};
    bus.WEI_IDX = 3'(b.idx);
    bus.ACT_LST = b.al;
    bus.WEI_LST = b.wl;
    bus.DIN_VLD = 1'b1;
    stall = 0;
    forever begin
      @(negedge clk);
      if (bus.DIN_RDY) break;
      stall++;
      if (stall > 500) begin
        chk("din_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.DIN_VLD = 1'b0;
  endtask

  task automatic run_row(input string tag);
    int st, w, n;
    build_model();
    cap_add.delete(); cap_dat.delete(); cap_lst.delete(); stalls.delete();
    foreach (bq[i]) begin
      send_beat(bq[i], st);
      stalls.push_back(st);
    end
    w = 0;
    forever begin
      @(negedge clk);
      if (is_idle && cap_add.size() >= exp_add.size()) break;
      w++;
      if (w > 3000) begin
        chk($sformatf("%s_idle_timeout", tag), 1, 0);
        break;
      end
    end
    chk($sformatf("%s_count", tag), cap_add.size(), exp_add.size());
    n = (cap_add.size() < exp_add.size()) ? cap_add.size() : exp_add.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_add%0d", tag, i), cap_add[i], exp_add[i]);
      chk($sformatf("%s_d0_%0d", tag, i), $signed(cap_dat[i][7:0]), exp_d0[i]);
      chk($sformatf("%s_d1_%0d", tag, i), $signed(cap_dat[i][15:8]), exp_d1[i]);
      chk($sformatf("%s_lst%0d", tag, i), cap_lst[i], exp_lst[i]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  h_add;
    logic [15:0] h_dat;
    logic        h_lst;
    int          w, n, a, st;
    beat_t       b;

    rst_n = 1'b0; rdy_rand = 1'b0; rdy_force = 1'b1;
    bus.DIN_VLD = 1'b0; bus.ACT_LST = 1'b0; bus.WEI_LST = 1'b0;
    bus.ACT_DAT = 8'd0; bus.ACT_ADD = 10'd0; bus.WEI_DAT = 16'd0; bus.WEI_IDX = 3'd0;
    set_cfg(1, 1, 1, 1, 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld_in_reset", bus.OUT_VLD, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vld", bus.OUT_VLD, 0);
    chk("rst_lst", bus.OUT_LST, 0);
    chk("rst_add", bus.OUT_ADD, 0);
    chk("rst_dat", bus.OUT_DAT, 0);
    chk("rst_idle", is_idle, 1);
    chk("rst_din_rdy", bus.DIN_RDY, 1);

    // Single last beat, plain and with ReLU.
    bq = '{mk(0, 0, 3, 2, -1, 1'b1)};
    run_row("t1");
    chk("t1_dat0", $signed(cap_dat[0][7:0]), 6);
    chk("t1_dat1", $signed(cap_dat[0][15:8]), -3);
    chk("t1_lst", cap_lst[0], 1);
    chk("t1_idle", is_idle, 1);
    set_cfg(1, 1, 1, 1, 0, 0, 0, 0, 1'b1);
    run_row("t2");
    chk("t2_dat1", $signed(cap_dat[0][15:8]), 0);

    // Retire on range: the ADD=3 beat stalls two cycles.
    set_cfg(1, 1, 1, 1, 0, 0, 0, 3, 1'b0);
    bq = '{mk(0, 0, 2, 1, 1, 1'b0), mk(3, 0, 1, 1, 1, 1'b1)};
    run_row("t3");
    chk("t3_stall", stalls[1], 2);
    chk("t3_add0", cap_add[0], 0);
    chk("t3_dat0", cap_dat[0], 16'h0202);
    chk("t3_add1", cap_add[1], 1);
    chk("t3_dat1", cap_dat[1], 16'h0000);

    // Rounding with SFT=1.
    set_cfg(1, 1, 1, 1, 0, 0, 1, 0, 1'b0);
    bq = '{mk(0, 0, 5, 1, -1, 1'b1)};
    run_row("t4a");
    chk("t4_pos5", $signed(cap_dat[0][7:0]), 3);
    chk("t4_neg5", $signed(cap_dat[0][15:8]), -2);
    bq = '{mk(0, 0, 4, 1, 1, 1'b1)};
    run_row("t4b");
    chk("t4_pos4", $signed(cap_dat[0][7:0]), 2);

    // Saturation and negative offset.
    set_cfg(1, 1, 1, 1, 0, 0, 0, 0, 1'b0);
    bq = '{mk(0, 0, 100, 3, -3, 1'b1)};
    run_row("t5a");
    chk("t5_sat_hi", $signed(cap_dat[0][7:0]), 127);
    chk("t5_sat_lo", $signed(cap_dat[0][15:8]), -128);
    set_cfg(1, 1, 1, 1, -10, -10, 0, 0, 1'b0);
    bq = '{mk(0, 0, 4, 1, 1, 1'b1)};
    run_row("t5b");
    chk("t5_ofs", $signed(cap_dat[0][7:0]), -6);

    // Randomized rows with random output backpressure.
    rdy_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      set_cfg($urandom_range(1, 3), $urandom_range(0, 3),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : $urandom_range(0, 65535),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : $urandom_range(0, 65535),
              int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 400)) - 200,
              $urandom_range(0, 20), 0, 1'($urandom_range(0, 1)));
      bq.delete();
      n = $urandom_range(1, 8);
      a = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        if (i > 0) a = a + $urandom_range(0, 2);
        b = mk(a, $urandom_range(0, 7), int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               1'b0);
        b.wl = (i == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
        b.al = (i == n - 1);
        bq.push_back(b);
      end
      w = a + int'($urandom_range(0, 6)) - 2;
      cfg_lst = 10'((w < 0) ? 0 : w);
      run_row($sformatf("rnd%0d", r));
    end
    rdy_rand = 1'b0;

    // Backpressure in FLUSH, then asynchronous reset.
    rdy_force = 1'b0;
    set_cfg(1, 1, 1, 1, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_beat(mk(0, 0, 3, 2, -1, 1'b1), st);
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.OUT_VLD) break;
      w++;
      if (w > 50) begin
        chk("bp_vld_timeout", 1, 0);
        break;
      end
    end
    h_add = bus.OUT_ADD; h_dat = bus.OUT_DAT; h_lst = bus.OUT_LST;
    chk("bp_dat", h_dat, 16'hFD06);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_vld%0d", i), bus.OUT_VLD, 1);
      chk($sformatf("bp_add%0d", i), bus.OUT_ADD, h_add);
      chk($sformatf("bp_dat%0d", i), bus.OUT_DAT, h_dat);
      chk($sformatf("bp_lst%0d", i), bus.OUT_LST, h_lst);
      chk($sformatf("bp_busy%0d", i), is_idle, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_vld", bus.OUT_VLD, 0);
    chk("arst_dat", bus.OUT_DAT, 0);
    chk("arst_idle", is_idle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_idle", is_idle, 1);
    chk("post_din_rdy", bus.DIN_RDY, 1);
    chk("post_vld", bus.OUT_VLD, 0);
    bq = '{mk(0, 0, 3, 2, -1, 1'b1)};
    run_row("post");
    chk("post_dat", cap_dat[0], 16'hFD06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eeg_pea_eng_pe_mc.md
Name: eeg_pea_eng_pe_mc

Overview:
Multi-output-channel successor to the single-lane conv PE. It accepts a sparse activation stream in which each beat carries NUM_OCH weights, and accumulates NUM_OCH parallel sliding psum windows, one per output channel. It retires completed output positions through per-channel requantisation (multiply, add, shift, round-half-up, saturate, optional ReLU). It sits between the activation/weight fetch stage and the output mux/ORAM writer.

Parameters:
NUM_OCH, 4, output channels processed in parallel
DATA_ACT_DW, 8, signed activation width
DATA_WEI_DW, 8, signed weight width per channel
DATA_OUT_DW, 8, signed output width per channel
DATA_SUM_DW, 24, psum width (two's-complement wrap)
DATA_SUM_NW, 8, psum window depth (slots per channel)
ARAM_ADD_AW, 10, activation/output address width
CONV_WEI_DW, 3, weight index width
CONV_RUN_DW, 3, stride/dilation step width
CONV_MUL_DW, 16, unsigned requant multiplier width per channel
CONV_ADD_DW, 24, signed requant offset width per channel

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
IS_IDLE  out  1  FSM in IDLE
CFG_CONV_RUN  in  CONV_RUN_DW  address step per retired output
CFG_CONV_PAD  in  CONV_WEI_DW  half kernel length
CFG_CONV_MUL  in  NUM_OCH*CONV_MUL_DW  per-channel multiplier, channel c at [c*W +: W]
CFG_CONV_ADD  in  NUM_OCH*CONV_ADD_DW  per-channel offset
CFG_CONV_SFT  in  5  shared right shift
CFG_CONV_LST  in  ARAM_ADD_AW  last output address of the row
CFG_RELU  in  1  clamp negative outputs to 0
DIN_VLD  in  1  input beat valid
DIN_RDY  out  1  input ready
ACT_LST  in  1  last activation of row
WEI_LST  in  1  last weight for this activation
ACT_DAT  in  DATA_ACT_DW  activation
ACT_ADD  in  ARAM_ADD_AW  activation address (non-decreasing)
WEI_DAT  in  NUM_OCH*DATA_WEI_DW  per-channel weights
WEI_IDX  in  CONV_WEI_DW  target slot relative to window head (< DATA_SUM_NW)
OUT_VLD  out  1  output valid
OUT_RDY  in  1  output ready
OUT_LST  out  1  final output of row
OUT_ADD  out  ARAM_ADD_AW  output address
OUT_DAT  out  NUM_OCH*DATA_OUT_DW  per-channel requantised outputs

Behaviour:
- Reset (asynchronous, active-low): FSM=IDLE; all psum slots, base_add and output register cleared; OUT_VLD=0, OUT_LST=0, OUT_ADD=0, OUT_DAT=0; DIN_RDY=1 after reset releases.
- FSM states: IDLE, FLOW, FLUSH.
  - IDLE->FLOW: on the first accepted beat. base_add<=ACT_ADD. The beat is accumulated into slot WEI_IDX.
  - FLOW->FLUSH: on an accepted beat with ACT_LST&WEI_LST. That beat is accumulated first.
  - FLUSH->IDLE: on the cycle the retirement carrying OUT_LST is taken by the handshake (OUT_VLD&OUT_RDY).
- Range test: out_range = ACT_ADD > base_add + PAD*RUN.
- FLOW with DIN_VLD & out_range:
  - DIN_RDY=0; the beat is not consumed.
  - If the output register is free (!OUT_VLD | OUT_RDY), retire the head: latch requant(slot0) for all channels, OUT_ADD<=base_add, shift window down one slot, top slot<=0, base_add+=RUN.
  - Repeats one retirement per cycle until the beat is in range.
- FLOW with DIN_VLD & !out_range: DIN_RDY=1. On accept, slot[WEI_IDX][c] += sext(ACT_DAT)*sext(WEI_DAT[c]), wrapped to DATA_SUM_DW.
- FLUSH: DIN_RDY=0. Retire one head per cycle while the output register is free. OUT_LST=1 on the retirement where base_add >= CFG_CONV_LST.
- Requant per channel, computed at full precision: m = psum*{0,MUL[c]} + ADD[c].
  - r = m[SFT-1] when SFT>0, else 0.
  - y = sat_signed((m>>>SFT) + r, DATA_OUT_DW).
  - If CFG_RELU and y<0, y=0.
- Output handshake: output register loads one cycle after the retire decision. OUT_VLD/OUT_DAT/OUT_ADD/OUT_LST hold stable while OUT_VLD & !OUT_RDY. OUT_VLD clears on a handshake with no new retirement.
- Accept and retire never occur in the same cycle.
- CFG_* are sampled live and must be stable whenever !IS_IDLE.
- A beat with WEI_IDX >= DATA_SUM_NW is a protocol violation; behaviour is undefined.
- Mid-operation reset discards all psums and any pending output. OUT_VLD drops asynchronously.

Test Plan:
- NUM_OCH=2, PAD=1, RUN=1, MUL=1, ADD=0, SFT=0, LST=0; single beat ADD=0, IDX=0, act=3, wei={2,-1}, last -> one output, OUT_ADD=0, OUT_DAT={6,-3}, OUT_LST=1; FSM returns to IDLE.
- Same stimulus with CFG_RELU=1 -> OUT_DAT={6,0}.
- Retire on range: beat (ADD=0, IDX=0, act=2, wei={1,1}), then beat at ADD=3 -> DIN_RDY=0 for 2 cycles; outputs at OUT_ADD 0 then 1 with data {2,2} then {0,0}; the ADD=3 beat is accepted in the 3rd cycle.
- Rounding: psum=5, MUL=1, SFT=1 -> 3; psum=-5 -> -2; psum=4 -> 2.
- Saturation: psum=300 -> 127; psum=-300 -> -128; ADD=-10 with psum=4 -> -6.
- Backpressure/reset: hold OUT_RDY=0 for 5 cycles during FLUSH -> OUT_* stable and no retirement; then assert rst_n=0 -> OUT_VLD=0 immediately, IS_IDLE=1 after release.
